// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writes, selects forwarding data per read
// port and raises load-use stalls. Define HAZARD_STATS_EN to add stall/forward counters.
module hazard_scoreboard #(
  parameter int XLEN             = 32,
  parameter int NUM_REGS         = 32,
  parameter int NUM_RD_PORTS     = 2,
  parameter int PIPE_DEPTH       = 3,
  parameter int LOAD_READY_STAGE = 2,
  localparam int AW              = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         issue_valid_i,
  input  logic                         issue_rd_en_i,
  input  logic [AW-1:0]                issue_rd_i,
  input  logic                         issue_is_load_i,
  input  logic [NUM_RD_PORTS*AW-1:0]   rs_addr_i,
  input  logic                         advance_i,
  input  logic                         flush_i,
  input  logic [PIPE_DEPTH*XLEN-1:0]   stage_data_i,
  output logic [NUM_RD_PORTS-1:0]      fwd_en_o,
  output logic [NUM_RD_PORTS*XLEN-1:0] fwd_data_o,
  output logic                         stall_o,
  output logic [31:0]                  stall_cnt_o,
  output logic [31:0]                  fwd_cnt_o
);

  logic [PIPE_DEPTH-1:0]   vld_q, vld_d;
  logic [PIPE_DEPTH-1:0]   ld_q;
  logic [AW-1:0]           rd_q [PIPE_DEPTH];
  logic [NUM_RD_PORTS-1:0] late_ld;

  // Oldest-to-youngest scan so the youngest matching stage overwrites older ones.
  always_comb begin
    fwd_en_o   = '0;
    fwd_data_o = '0;
    late_ld    = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      for (int s = PIPE_DEPTH - 1; s >= 0; s--) begin
        if (vld_q[s] && (rd_q[s] == rs_addr_i[p*AW +: AW]) && (rd_q[s] != '0)) begin
          fwd_en_o[p]                  = 1'b1;
          fwd_data_o[p*XLEN +: XLEN]   = stage_data_i[s*XLEN +: XLEN];
          late_ld[p]                   = ld_q[s] && (s < LOAD_READY_STAGE);
        end
      end
    end
    stall_o = issue_valid_i && (|late_ld);
  end

  always_comb begin
    vld_d = vld_q;
    if (advance_i) begin
      vld_d = {vld_q[PIPE_DEPTH-2:0],
               issue_valid_i && issue_rd_en_i && !stall_o && !flush_i};
      // The squashed EX instruction moving into stage 1 must never write.
      if (flush_i) vld_d[1] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_q <= '0;
    else       vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    if (advance_i) begin
      rd_q[0] <= issue_rd_i;
      ld_q[0] <= issue_is_load_i;
      for (int s = 1; s < PIPE_DEPTH; s++) begin
        rd_q[s] <= rd_q[s-1];
        ld_q[s] <= ld_q[s-1];
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;
  logic [31:0] fwd_inc;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  always_comb begin
    fwd_inc = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++)
      fwd_inc = fwd_inc + 32'(fwd_en_o[p] & ~stall_o);
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (advance_i) begin
      stall_cnt_d = sat_add(stall_cnt_q, 32'(stall_o));
      fwd_cnt_d   = sat_add(fwd_cnt_q, fwd_inc);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign fwd_cnt_o   = fwd_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign fwd_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard (default parameters): directed scenarios plus random traffic
// checked against a youngest-first list model of in-flight writes.
module tb_hazard_scoreboard;
  localparam int PD = 3;
  localparam int LRS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_rd_en, issue_is_load;
  logic [4:0]  issue_rd;
  logic [9:0]  rs_addr;
  logic        advance, flush;
  logic [95:0] stage_data;
  logic [1:0]  fwd_en;
  logic [63:0] fwd_data;
  logic        stall;
  logic [31:0] stall_cnt, fwd_cnt;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset),
    .issue_valid_i(issue_valid), .issue_rd_en_i(issue_rd_en), .issue_rd_i(issue_rd),
    .issue_is_load_i(issue_is_load), .rs_addr_i(rs_addr), .advance_i(advance),
    .flush_i(flush), .stage_data_i(stage_data), .fwd_en_o(fwd_en), .fwd_data_o(fwd_data),
    .stall_o(stall), .stall_cnt_o(stall_cnt), .fwd_cnt_o(fwd_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Model: index 0 is the youngest in-flight write.
  logic        mv  [PD];
  logic [4:0]  mrd [PD];
  logic        mld [PD];
  logic [31:0] m_sc, m_fc;
  logic [1:0]  e_en;
  logic [63:0] e_data;
  logic        e_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int s = 0; s < PD; s++) begin mv[s] = 1'b0; mrd[s] = '0; mld[s] = 1'b0; end
    m_sc = '0;
    m_fc = '0;
  endtask

  task automatic predict();
    logic [4:0] rs;
    logic found;
    e_en = '0; e_data = '0; e_stall = 1'b0;
    for (int p = 0; p < 2; p++) begin
      rs = rs_addr[p*5 +: 5];
      found = 1'b0;
      for (int s = 0; s < PD; s++) begin
        if (!found && rs != 0 && mv[s] && mrd[s] == rs) begin
          found = 1'b1;
          e_en[p] = 1'b1;
          e_data[p*32 +: 32] = stage_data[s*32 +: 32];
          if (issue_valid && mld[s] && s < LRS) e_stall = 1'b1;
        end
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    predict();
    chk("fwd_en", {62'd0, fwd_en}, {62'd0, e_en});
    chk("fwd_data", fwd_data, e_data);
    chk("stall", {63'd0, stall}, {63'd0, e_stall});
    chk("stall_cnt", {32'd0, stall_cnt}, {32'd0, m_sc});
    chk("fwd_cnt", {32'd0, fwd_cnt}, {32'd0, m_fc});
  endtask

  task automatic clock();
    longint sum;
    @(posedge clk);
    if (advance) begin
`ifdef HAZARD_STATS_EN
      if (e_stall && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      sum = longint'(m_fc) + (e_stall ? 0 : (int'(e_en[0]) + int'(e_en[1])));
      m_fc = (sum > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
`else
      sum = 0;
`endif
      for (int s = PD - 1; s > 0; s--) begin
        mv[s] = mv[s-1]; mrd[s] = mrd[s-1]; mld[s] = mld[s-1];
      end
      if (flush) mv[1] = 1'b0;
      mv[0]  = issue_valid && issue_rd_en && !e_stall && !flush;
      mrd[0] = issue_rd;
      mld[0] = issue_is_load;
    end
    #1;
  endtask

  task automatic drive(input logic iv, input logic [4:0] rd, input logic ld,
                       input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic adv, input logic fl);
    issue_valid = iv; issue_rd_en = iv; issue_rd = rd; issue_is_load = ld;
    rs_addr = {rs1, rs0}; advance = adv; flush = fl;
    stage_data = {$urandom, $urandom, $urandom};
  endtask

  task automatic step(input logic iv, input logic [4:0] rd, input logic ld,
                      input logic [4:0] rs0, input logic [4:0] rs1,
                      input logic adv, input logic fl);
    drive(iv, rd, ld, rs0, rs1, adv, fl);
    sample();
    clock();
  endtask

  initial begin
    reset = 1'b1;
    model_clear();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
    sample();
    chk("reset_fwd_en", {62'd0, fwd_en}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // ALU back-to-back
    step(1'b1, 5'd5, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
    drive(1'b0, 5'd0, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0);
    stage_data[31:0] = 32'hDEAD_BEEF;
    sample();
    chk("alu_en", {63'd0, fwd_en[0]}, 64'd1);
    chk("alu_data", {32'd0, fwd_data[31:0]}, {32'd0, 32'hDEAD_BEEF});
    chk("alu_stall", {63'd0, stall}, 64'd0);
    clock();

    // Load-use: reader sees the load at stage 1, stalls once, then forwards from stage 2
    step(1'b1, 5'd7, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0);
    step(1'b1, 5'd8, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
    drive(1'b1, 5'd10, 1'b0, 5'd7, 5'd0, 1'b1, 1'b0);
    sample();
    chk("lu_stall", {63'd0, stall}, 64'd1);
    chk("lu_en_during_stall", {63'd0, fwd_en[0]}, 64'd1);
    clock();
    drive(1'b1, 5'd10, 1'b0, 5'd7, 5'd0, 1'b1, 1'b0);
    sample();
    chk("lu_stall_after", {63'd0, stall}, 64'd0);
    chk("lu_data_s2", {32'd0, fwd_data[31:0]}, {32'd0, stage_data[95:64]});
    clock();

    // Youngest wins
    step(1'b1, 5'd3, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
    step(1'b1, 5'd11, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
    step(1'b1, 5'd3, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
    drive(1'b0, 5'd0, 1'b0, 5'd3, 5'd3, 1'b1, 1'b0);
    stage_data[31:0] = 32'hAAAA_0001;
    stage_data[95:64] = 32'hBBBB_0002;
    sample();
    chk("yw_data", fwd_data, {32'hAAAA_0001, 32'hAAAA_0001});
    clock();

    // x0 never forwards; x9 retires after PIPE_DEPTH advances
    step(1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
    sample();
    chk("x0_en", {62'd0, fwd_en}, 64'd0);
    clock();
    step(1'b1, 5'd9, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < PD; i++) step(1'b0, 5'd0, 1'b0, 5'd9, 5'd0, 1'b1, 1'b0);
    drive(1'b0, 5'd0, 1'b0, 5'd9, 5'd0, 1'b1, 1'b0);
    sample();
    chk("retired_en", {62'd0, fwd_en}, 64'd0);
    clock();

    // Flush squashes issuing x4 and stage-0 x6
    step(1'b1, 5'd6, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
    step(1'b1, 5'd4, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1);
    drive(1'b0, 5'd0, 1'b0, 5'd4, 5'd6, 1'b1, 1'b0);
    sample();
    chk("flush_en", {62'd0, fwd_en}, 64'd0);
    clock();

    // Freeze with advance low
    step(1'b1, 5'd12, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
    step(1'b1, 5'd13, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd14, 1'b0, 5'd12, 5'd13, 1'b0, 1'b0);
      sample();
      chk("hold_en", {62'd0, fwd_en}, 64'd3);
      clock();
    end

    // Reset mid-operation
    step(1'b1, 5'd1, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
    step(1'b1, 5'd2, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
    step(1'b1, 5'd15, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0);
    drive(1'b1, 5'd16, 1'b0, 5'd1, 5'd15, 1'b1, 1'b0);
    sample();
    chk("pre_reset_en", {62'd0, fwd_en}, 64'd3);
    #2 reset = 1'b1;
    #1;
    chk("async_en", {62'd0, fwd_en}, 64'd0);
    chk("async_data", fwd_data, 64'd0);
    chk("async_stall", {63'd0, stall}, 64'd0);
    chk("async_cnt", {stall_cnt, fwd_cnt}, 64'd0);
    model_clear();
    @(posedge clk); #1;
    reset = 1'b0;
    step(1'b1, 5'd0, 1'b0, 5'd1, 5'd2, 1'b1, 1'b0);

    // Random traffic, narrow register range to force collisions
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom_range(0, 1),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0);
      issue_rd_en = $urandom_range(0, 3) != 0;
      sample();
      clock();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
